// File: rtl/sr_flop_bank.sv
// N-channel clocked SR flip-flop bank with per-channel debounce,
// selectable S=R=1 resolution and illegal-event flagging/counting.
module sr_flop_bank #(
   parameter int N     = 4,
   parameter int MODE  = 0,
   parameter int DEB   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     S,
   input  logic [N-1:0]     R,
   input  logic             clear,
   output logic [N-1:0]     Q,
   output logic [N-1:0]     Qn,
   output logic [N-1:0]     illegal,
   output logic [N-1:0]     err_sticky,
   output logic [CNT_W-1:0] err_count
);

   localparam int RW = $clog2(DEB + 1);
   localparam int SW = CNT_W + $clog2(N + 1) + 1;
   localparam logic [RW-1:0] RUN_MAX = RW'(DEB);
   localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

   logic [N-1:0][1:0]    prev_cmd;
   logic [N-1:0][RW-1:0] run;

   logic [N-1:0][1:0]    cmd;
   logic [N-1:0][RW-1:0] run_nx;
   logic [N-1:0]         same;
   logic [N-1:0]         qual;
   logic [N-1:0]         ev;
   logic [N-1:0]         q_nx;
   logic [SW-1:0]        pop;
   logic [SW-1:0]        acc;
   logic [CNT_W-1:0]     cnt_nx;
   logic [N-1:0]         stk_nx;

   always_comb begin
      cmd    = '0;
      run_nx = '0;
      same   = '0;
      qual   = '0;
      ev     = '0;
      q_nx   = Q;
      for (int i = 0; i < N; i++) begin
         cmd[i]  = {S[i], R[i]};
         same[i] = (cmd[i] == prev_cmd[i]);
         if (same[i])
            run_nx[i] = (run[i] == RUN_MAX) ? RUN_MAX : run[i] + RW'(1);
         else
            run_nx[i] = RW'(1);
         qual[i] = (run_nx[i] == RUN_MAX);
         // a held, already-qualified 11 is not a new event
         ev[i] = qual[i] && (cmd[i] == 2'b11)
                 && !(same[i] && run[i] == RUN_MAX);
         if (qual[i]) begin
            unique case (cmd[i])
               2'b10: q_nx[i] = 1'b1;
               2'b01: q_nx[i] = 1'b0;
               2'b11: begin
                  case (MODE)
                     1:       q_nx[i] = 1'b1;
                     2:       q_nx[i] = 1'b0;
                     3:       q_nx[i] = ~Q[i];
                     default: q_nx[i] = Q[i];
                  endcase
               end
               default: q_nx[i] = Q[i];
            endcase
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++)
         pop = pop + SW'(ev[i]);
      // new events survive a simultaneous clear
      acc    = (clear ? '0 : SW'(err_count)) + pop;
      cnt_nx = (acc > SAT) ? SAT[CNT_W-1:0] : acc[CNT_W-1:0];
      stk_nx = clear ? ev : (err_sticky | ev);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_cmd   <= '0;
         run        <= '0;
         Q          <= '0;
         illegal    <= '0;
         err_sticky <= '0;
         err_count  <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            prev_cmd[i] <= cmd[i];
            run[i]      <= run_nx[i];
         end
         Q          <= q_nx;
         illegal    <= ev;
         err_sticky <= stk_nx;
         err_count  <= cnt_nx;
      end
   end

   assign Qn = ~Q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Bench for sr_flop_bank: five instances with different MODE/DEB/CNT_W
// share one stimulus and are checked against a history-based model.
module tb_sr_flop_bank;

   localparam int NI = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] S = '0;
   logic [3:0] R = '0;

   logic [3:0] q   [NI];
   logic [3:0] qn  [NI];
   logic [3:0] ill [NI];
   logic [3:0] stk [NI];
   logic [7:0] cnt [NI];
   logic [7:0] c0, c1, c3, c4;
   logic [1:0] c2;

   int checks = 0;
   int errors = 0;

   int mdeb [NI] = '{1, 1, 1, 1, 3};
   int mmode[NI] = '{0, 1, 2, 3, 0};
   int mmax [NI] = '{255, 255, 3, 255, 255};

   logic [3:0] mq  [NI];
   logic [3:0] mqn [NI];
   logic [3:0] mill[NI];
   logic [3:0] mstk[NI];
   int         mcnt[NI];
   int         hist[4][$];
   int         tr[4];
   int         cm[4];
   logic [3:0] ev;
   int         pop;

   always #5 clk = ~clk;

   sr_flop_bank #(.N(4), .MODE(0), .DEB(1), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clear(clear),
      .Q(q[0]), .Qn(qn[0]), .illegal(ill[0]),
      .err_sticky(stk[0]), .err_count(c0));
   sr_flop_bank #(.N(4), .MODE(1), .DEB(1), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clear(clear),
      .Q(q[1]), .Qn(qn[1]), .illegal(ill[1]),
      .err_sticky(stk[1]), .err_count(c1));
   sr_flop_bank #(.N(4), .MODE(2), .DEB(1), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clear(clear),
      .Q(q[2]), .Qn(qn[2]), .illegal(ill[2]),
      .err_sticky(stk[2]), .err_count(c2));
   sr_flop_bank #(.N(4), .MODE(3), .DEB(1), .CNT_W(8)) u3 (
      .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clear(clear),
      .Q(q[3]), .Qn(qn[3]), .illegal(ill[3]),
      .err_sticky(stk[3]), .err_count(c3));
   sr_flop_bank #(.N(4), .MODE(0), .DEB(3), .CNT_W(8)) u4 (
      .clk(clk), .rst_n(rst_n), .S(S), .R(R), .clear(clear),
      .Q(q[4]), .Qn(qn[4]), .illegal(ill[4]),
      .err_sticky(stk[4]), .err_count(c4));

   always_comb begin
      cnt[0] = c0;
      cnt[1] = c1;
      cnt[2] = {6'b0, c2};
      cnt[3] = c3;
      cnt[4] = c4;
   end

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h", nm, k, act, exp);
      end
   endtask

   // model: a command qualifies once its trailing run of identical
   // samples since reset reaches DEB; an event is the run hitting DEB
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int k = 0; k < NI; k++) begin
            mq[k] = '0; mqn[k] = '1; mill[k] = '0;
            mstk[k] = '0; mcnt[k] = 0;
         end
         for (int i = 0; i < 4; i++) hist[i].delete();
      end else begin
         for (int i = 0; i < 4; i++) begin
            cm[i] = {30'd0, S[i], R[i]};
            hist[i].push_back(cm[i]);
            if (hist[i].size() > 8) void'(hist[i].pop_front());
            tr[i] = 0;
            for (int j = hist[i].size() - 1; j >= 0; j--) begin
               if (hist[i][j] != cm[i]) break;
               tr[i]++;
            end
         end
         for (int k = 0; k < NI; k++) begin
            ev = '0;
            for (int i = 0; i < 4; i++) begin
               if (tr[i] >= mdeb[k]) begin
                  if (cm[i] == 2) mq[k][i] = 1'b1;
                  else if (cm[i] == 1) mq[k][i] = 1'b0;
                  else if (cm[i] == 3) begin
                     if (mmode[k] == 1) mq[k][i] = 1'b1;
                     else if (mmode[k] == 2) mq[k][i] = 1'b0;
                     else if (mmode[k] == 3) mq[k][i] = ~mq[k][i];
                  end
               end
               if (cm[i] == 3 && tr[i] == mdeb[k]) ev[i] = 1'b1;
            end
            pop = $countones(ev);
            mcnt[k] = (clear ? 0 : mcnt[k]) + pop;
            if (mcnt[k] > mmax[k]) mcnt[k] = mmax[k];
            mstk[k] = clear ? ev : (mstk[k] | ev);
            mill[k] = ev;
            mqn[k] = ~mq[k];
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("Q", k, 32'(q[k]), 32'(mq[k]));
         chk("Qn", k, 32'(qn[k]), 32'(mqn[k]));
         chk("illegal", k, 32'(ill[k]), 32'(mill[k]));
         chk("sticky", k, 32'(stk[k]), 32'(mstk[k]));
         chk("count", k, 32'(cnt[k]), mcnt[k]);
      end
   end

   task automatic cyc(input logic [3:0] s, input logic [3:0] r,
                      input logic c);
      S = s; R = r; clear = c;
      @(negedge clk);
   endtask

   initial begin
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_q", 0, 32'(q[0]), 32'h0);
      chk("rst_qn", 0, 32'(qn[0]), 32'hf);
      chk("rst_cnt", 0, 32'(cnt[0]), 32'h0);
      chk("rst_stk", 0, 32'(stk[0]), 32'h0);

      cyc(4'h1, 4'h0, 1'b0);
      chk("set_q", 0, 32'(q[0]), 32'h1);
      chk("set_qn", 0, 32'(qn[0]), 32'he);
      chk("deb_1smp", 4, 32'(q[4]), 32'h0);
      cyc(4'h0, 4'h1, 1'b0);
      chk("rst_q", 0, 32'(q[0]), 32'h0);
      chk("rst_qn", 0, 32'(qn[0]), 32'hf);

      cyc(4'h1, 4'h0, 1'b0);
      cyc(4'h1, 4'h0, 1'b0);
      chk("deb_2smp", 4, 32'(q[4]), 32'h0);
      repeat (3) cyc(4'h0, 4'h0, 1'b0);
      chk("deb_abort", 4, 32'(q[4]), 32'h0);
      repeat (2) cyc(4'h1, 4'h0, 1'b0);
      chk("deb_2of3", 4, 32'(q[4]), 32'h0);
      cyc(4'h1, 4'h0, 1'b0);
      chk("deb_3of3", 4, 32'(q[4]), 32'h1);

      repeat (3) cyc(4'h0, 4'hf, 1'b0);
      cyc(4'h0, 4'h0, 1'b1);
      chk("clr_stk", 0, 32'(stk[0]), 32'h0);
      chk("clr_cnt", 0, 32'(cnt[0]), 32'h0);
      cyc(4'h1, 4'h1, 1'b0);
      for (int k = 0; k < 4; k++) chk("ill_1st", k, 32'(ill[k]), 32'h1);
      chk("m3_t1", 3, 32'(q[3]), 32'h1);
      cyc(4'h1, 4'h1, 1'b0);
      for (int k = 0; k < 4; k++) chk("ill_held", k, 32'(ill[k]), 32'h0);
      chk("m3_t2", 3, 32'(q[3]), 32'h0);
      cyc(4'h1, 4'h1, 1'b0);
      chk("m3_t3", 3, 32'(q[3]), 32'h1);
      chk("ill_deb3", 4, 32'(ill[4]), 32'h1);
      cyc(4'h1, 4'h1, 1'b0);
      chk("m0_q", 0, 32'(q[0]), 32'h0);
      chk("m1_q", 1, 32'(q[1]), 32'h1);
      chk("m2_q", 2, 32'(q[2]), 32'h0);
      chk("m3_t4", 3, 32'(q[3]), 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk("ev_stk", k, 32'(stk[k]), 32'h1);
         chk("ev_cnt", k, 32'(cnt[k]), 32'h1);
      end

      cyc(4'h0, 4'h0, 1'b0);
      cyc(4'hf, 4'hf, 1'b0);
      chk("cnt_add4", 0, 32'(cnt[0]), 32'd5);
      chk("cnt_sat", 2, 32'(cnt[2]), 32'd3);
      cyc(4'h0, 4'h0, 1'b0);
      cyc(4'hf, 4'hf, 1'b0);
      chk("cnt_add4b", 0, 32'(cnt[0]), 32'd9);
      chk("cnt_sat2", 2, 32'(cnt[2]), 32'd3);

      cyc(4'h0, 4'h0, 1'b1);
      chk("clr_stk", 0, 32'(stk[0]), 32'h0);
      chk("clr_cnt", 0, 32'(cnt[0]), 32'h0);
      cyc(4'h0, 4'h0, 1'b0);
      cyc(4'h4, 4'h4, 1'b1);
      chk("clr_ev_stk", 0, 32'(stk[0]), 32'h4);
      chk("clr_ev_cnt", 0, 32'(cnt[0]), 32'h1);
      chk("clr_ev_ill", 0, 32'(ill[0]), 32'h4);

      repeat (3) cyc(4'h0, 4'h0, 1'b0);
      repeat (2) cyc(4'h1, 4'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_q", 0, 32'(q[0]), 32'h0);
      chk("arst_qn", 0, 32'(qn[0]), 32'hf);
      chk("arst_stk", 0, 32'(stk[0]), 32'h0);
      chk("arst_cnt", 0, 32'(cnt[0]), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cyc(4'h1, 4'h0, 1'b0);
      chk("arst_2smp", 4, 32'(q[4]), 32'h0);
      cyc(4'h1, 4'h0, 1'b0);
      chk("arst_3smp", 4, 32'(q[4]), 32'h1);

      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(3) == 0) begin
               S[i] = 1'($urandom_range(1));
               R[i] = 1'($urandom_range(1));
            end
         end
         clear = ($urandom_range(15) == 0);
         if ($urandom_range(499) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
